// File: rtl/ir_sequencer.sv
// ir_sequencer: splits the instruction-memory word stream into opcodes and
// bubble instructions, assembling the extension words that follow an
// immediate-flagged opcode into one wide immediate. Supports stall, flush
// on jump/interrupt, and an asynchronous active-low reset.
module ir_sequencer #(
    parameter int               WIDTH        = 16,
    parameter int               IMM_WORDS    = 2,
    parameter int               IMM_BIT      = 2,
    parameter int               DST_LSB      = 3,
    parameter int               DST_MSB      = 6,
    parameter logic [WIDTH-1:0] BUBBLE_INSTR = 16'h07F8
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic [WIDTH-1:0]           inWord,
    input  logic                       inValid,
    input  logic                       stall,
    input  logic                       jumpBit,
    input  logic                       interruptBit,
    output logic [WIDTH-1:0]           instruction,
    output logic [WIDTH*IMM_WORDS-1:0] immediate,
    output logic                       outValid,
    output logic                       iamBubble,
    output logic                       immDone,
    output logic                       busy
);

    localparam int CNT_W = (IMM_WORDS > 1) ? $clog2(IMM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IMM_WORDS - 1);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [CNT_W-1:0]           cnt;
    logic [CNT_W-1:0]           cnt_nxt;
    logic [WIDTH-1:0]           saved_op;
    logic [WIDTH-1:0]           saved_nxt;
    logic [WIDTH-1:0]           instr_nxt;
    logic [WIDTH*IMM_WORDS-1:0] imm_nxt;
    logic                       valid_nxt;
    logic                       bubble_nxt;
    logic                       done_nxt;
    logic [WIDTH-1:0]           bubble_word;
    logic                       flush;

    assign flush = jumpBit | interruptBit;
    assign busy  = (state == COLLECT);

    // Bubble carries the saved opcode's destination field so later stages can forward to it
    always_comb begin
        bubble_word                  = BUBBLE_INSTR;
        bubble_word[DST_MSB:DST_LSB] = saved_op[DST_MSB:DST_LSB];
    end

    // Next-state and output decode: flush beats stall, stall freezes everything
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        saved_nxt  = saved_op;
        instr_nxt  = instruction;
        imm_nxt    = immediate;
        valid_nxt  = outValid;
        bubble_nxt = iamBubble;
        done_nxt   = immDone;

        if (flush || !stall) begin
            if (flush) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end

            if (!inValid) begin
                valid_nxt  = 1'b0;
                bubble_nxt = 1'b0;
                done_nxt   = 1'b0;
            end else if (flush || state == IDLE) begin
                instr_nxt  = inWord;
                valid_nxt  = 1'b1;
                bubble_nxt = 1'b0;
                done_nxt   = 1'b0;
                if (inWord[IMM_BIT]) begin
                    saved_nxt = inWord;
                    imm_nxt   = '0;
                    state_nxt = COLLECT;
                    cnt_nxt   = '0;
                end
            end else begin
                for (int k = 0; k < IMM_WORDS; k++) begin
                    if (cnt == CNT_W'(k)) begin
                        imm_nxt[k*WIDTH +: WIDTH] = inWord;
                    end
                end
                instr_nxt  = bubble_word;
                valid_nxt  = 1'b1;
                bubble_nxt = 1'b1;
                if (cnt == LAST_CNT) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    done_nxt  = 1'b0;
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
        end
    end

    // State and output registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state       <= IDLE;
            cnt         <= '0;
            saved_op    <= '0;
            instruction <= '0;
            immediate   <= '0;
            outValid    <= 1'b0;
            iamBubble   <= 1'b0;
            immDone     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            saved_op    <= saved_nxt;
            instruction <= instr_nxt;
            immediate   <= imm_nxt;
            outValid    <= valid_nxt;
            iamBubble   <= bubble_nxt;
            immDone     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_ir_sequencer.sv
// tb_ir_sequencer: directed vector table for the documented scenarios,
// a hand-written asynchronous reset check, then randomized traffic
// compared against a word-counting reference model.
module tb_ir_sequencer;

    localparam int WIDTH     = 16;
    localparam int IMM_WORDS = 2;
    localparam logic [15:0] DST_MASK = 16'h0078;
    localparam logic [15:0] BUBBLE   = 16'h07F8;

    logic                       clk;
    logic                       rstN;
    logic [WIDTH-1:0]           inWord;
    logic                       inValid;
    logic                       stall;
    logic                       jumpBit;
    logic                       interruptBit;
    logic [WIDTH-1:0]           instruction;
    logic [WIDTH*IMM_WORDS-1:0] immediate;
    logic                       outValid;
    logic                       iamBubble;
    logic                       immDone;
    logic                       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [15:0] w;
        logic        st;
        logic        jb;
        logic        ib;
        logic [15:0] e_instr;
        logic [31:0] e_imm;
        logic        e_ov;
        logic        e_bub;
        logic        e_done;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: number of extension words still expected
    int          m_pending;
    logic [15:0] m_saved;
    logic [15:0] m_imm [IMM_WORDS];
    logic [15:0] m_instr;
    logic        m_ov;
    logic        m_bub;
    logic        m_done;

    ir_sequencer dut (
        .clk          (clk),
        .rstN         (rstN),
        .inWord       (inWord),
        .inValid      (inValid),
        .stall        (stall),
        .jumpBit      (jumpBit),
        .interruptBit (interruptBit),
        .instruction  (instruction),
        .immediate    (immediate),
        .outValid     (outValid),
        .iamBubble    (iamBubble),
        .immDone      (immDone),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [15:0] w,
                                 input logic st, input logic jb, input logic ib);
        inValid      = v;
        inWord       = w;
        stall        = st;
        jumpBit      = jb;
        interruptBit = ib;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] e_instr,
                               input logic [31:0] e_imm, input logic e_ov,
                               input logic e_bub, input logic e_done, input logic e_busy);
        checks += 6;
        if (instruction !== e_instr) begin
            errors++;
            $display("[TB] FAIL %s instruction got %h expected %h", tag, instruction, e_instr);
        end
        if (immediate !== e_imm) begin
            errors++;
            $display("[TB] FAIL %s immediate got %h expected %h", tag, immediate, e_imm);
        end
        if (outValid !== e_ov) begin
            errors++;
            $display("[TB] FAIL %s outValid got %b expected %b", tag, outValid, e_ov);
        end
        if (iamBubble !== e_bub) begin
            errors++;
            $display("[TB] FAIL %s iamBubble got %b expected %b", tag, iamBubble, e_bub);
        end
        if (immDone !== e_done) begin
            errors++;
            $display("[TB] FAIL %s immDone got %b expected %b", tag, immDone, e_done);
        end
        if (busy !== e_busy) begin
            errors++;
            $display("[TB] FAIL %s busy got %b expected %b", tag, busy, e_busy);
        end
    endtask

    function automatic void modelReset();
        m_pending = 0;
        m_saved   = '0;
        for (int k = 0; k < IMM_WORDS; k++) m_imm[k] = '0;
        m_instr = '0;
        m_ov    = 1'b0;
        m_bub   = 1'b0;
        m_done  = 1'b0;
    endfunction

    function automatic void modelStep(input logic v, input logic [15:0] w,
                                      input logic st, input logic jb, input logic ib);
        logic flush;
        flush = jb | ib;
        if (flush) m_pending = 0;
        if (!flush && st) return;
        if (!v) begin
            m_ov   = 1'b0;
            m_bub  = 1'b0;
            m_done = 1'b0;
        end else if (m_pending == 0) begin
            m_instr = w;
            m_ov    = 1'b1;
            m_bub   = 1'b0;
            m_done  = 1'b0;
            if (w[2]) begin
                m_saved = w;
                for (int k = 0; k < IMM_WORDS; k++) m_imm[k] = '0;
                m_pending = IMM_WORDS;
            end
        end else begin
            m_imm[IMM_WORDS - m_pending] = w;
            m_instr   = (BUBBLE & ~DST_MASK) | (m_saved & DST_MASK);
            m_ov      = 1'b1;
            m_bub     = 1'b1;
            m_pending = m_pending - 1;
            m_done    = (m_pending == 0);
        end
    endfunction

    function automatic logic [31:0] modelImm();
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < IMM_WORDS; k++) r[k*16 +: 16] = m_imm[k];
        return r;
    endfunction

    initial begin
        // plain stream
        vecs.push_back('{1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 16'h1000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 16'h2000, 1'b0, 1'b0, 1'b0, 16'h2000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
        // immediate
        vecs.push_back('{1'b1, 16'h0024, 1'b0, 1'b0, 1'b0, 16'h0024, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h07A0, 32'h0000BEEF, 1'b1, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h07A0, 32'h1234BEEF, 1'b1, 1'b1, 1'b1, 1'b0});
        // stall for three cycles with changing input
        vecs.push_back('{1'b1, 16'h0024, 1'b0, 1'b0, 1'b0, 16'h0024, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0024, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 16'h1111, 1'b1, 1'b0, 1'b0, 16'h0024, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 16'h0024, 1'b1, 1'b0, 1'b0, 16'h0024, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h07A0, 32'h0000BEEF, 1'b1, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h07A0, 32'h1234BEEF, 1'b1, 1'b1, 1'b1, 1'b0});
        // flush by jump
        vecs.push_back('{1'b1, 16'h0024, 1'b0, 1'b0, 1'b0, 16'h0024, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h07A0, 32'h0000BEEF, 1'b1, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 16'h3000, 1'b0, 1'b1, 1'b0, 16'h3000, 32'h0000BEEF, 1'b1, 1'b0, 1'b0, 1'b0});
        // flush by interrupt while stalled
        vecs.push_back('{1'b1, 16'h0024, 1'b0, 1'b0, 1'b0, 16'h0024, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h07A0, 32'h0000BEEF, 1'b1, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 16'h3000, 1'b1, 1'b0, 1'b1, 16'h3000, 32'h0000BEEF, 1'b1, 1'b0, 1'b0, 1'b0});
        // gap inside an immediate sequence
        vecs.push_back('{1'b1, 16'h0024, 1'b0, 1'b0, 1'b0, 16'h0024, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 16'h0024, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 16'h6666, 1'b0, 1'b0, 1'b0, 16'h0024, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h07A0, 32'h0000BEEF, 1'b1, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h07A0, 32'h1234BEEF, 1'b1, 1'b1, 1'b1, 1'b0});
        // extension words carrying IMM_BIT never restart the sequence
        vecs.push_back('{1'b1, 16'h0024, 1'b0, 1'b0, 1'b0, 16'h0024, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 16'h07A0, 32'h00000004, 1'b1, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 16'h07A0, 32'h00040004, 1'b1, 1'b1, 1'b1, 1'b0});
        // flush with no valid word clears the flags and leaves COLLECT
        vecs.push_back('{1'b1, 16'h0024, 1'b0, 1'b0, 1'b0, 16'h0024, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0024, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});

        rstN         = 1'b0;
        inWord       = '0;
        inValid      = 1'b0;
        stall        = 1'b0;
        jumpBit      = 1'b0;
        interruptBit = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_state", 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rstN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].v, vecs[i].w, vecs[i].st, vecs[i].jb, vecs[i].ib);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_imm,
                        vecs[i].e_ov, vecs[i].e_bub, vecs[i].e_done, vecs[i].e_busy);
        end

        // asynchronous reset in the middle of COLLECT, no clock edge involved
        applyStimulus(1'b1, 16'h0024, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_async_reset", 16'h07A0, 32'h0000BEEF, 1'b1, 1'b1, 1'b0, 1'b1);
        rstN = 1'b0;
        #1;
        checkOutput("async_reset", 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        checkOutput("held_in_reset", 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rstN = 1'b1;
        modelReset();

        // randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            logic        v;
            logic        st;
            logic        jb;
            logic        ib;
            logic [15:0] w;
            v  = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 5) == 0);
            jb = ($urandom_range(0, 15) == 0);
            ib = ($urandom_range(0, 19) == 0);
            w  = 16'($urandom);
            applyStimulus(v, w, st, jb, ib);
            modelStep(v, w, st, jb, ib);
            checkOutput($sformatf("rand%0d", n), m_instr, modelImm(), m_ov, m_bub,
                        m_done, (m_pending != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_sequencer.md
# ir_sequencer

Registered, parametrised successor to the fetch-stage instruction/immediate splitter. It consumes the raw word stream from instruction memory and emits one word per cycle to decode. An opcode word with its immediate flag set is followed by IMM_WORDS extension words; each extension word is turned into a bubble instruction, and the words are assembled into a wide immediate. It adds what the single-word splitter lacked: configurable width and immediate length, valid/stall handshake, asynchronous reset, and flush on jump/interrupt.

## Interface
- WIDTH, 16: instruction/memory word width.
- IMM_WORDS, 2: extension words per immediate instruction (1..4).
- IMM_BIT, 2: bit of an opcode word that flags a following immediate.
- DST_LSB, 3 / DST_MSB, 6: register field copied from the opcode into each bubble (forwarding target).
- BUBBLE_INSTR, 16'h07F8: base encoding of the bubble instruction, before the DST field is overwritten.

- clk  in  1  clock, rising edge.
- rstN  in  1  asynchronous, active-low reset.
- inWord  in  WIDTH  word from instruction memory.
- inValid  in  1  inWord is valid this cycle.
- stall  in  1  hold all state and outputs.
- jumpBit  in  1  control-flow redirect (flush).
- interruptBit  in  1  interrupt entry (flush).
- instruction  out  WIDTH  opcode word or bubble.
- immediate  out  WIDTH*IMM_WORDS  assembled immediate; word k occupies bits [k*WIDTH +: WIDTH].
- outValid  out  1  instruction is valid.
- iamBubble  out  1  instruction is a bubble.
- immDone  out  1  final extension word captured; immediate is complete.
- busy  out  1  state is COLLECT.

## Operation
- States:
  - IDLE: expect an opcode word.
  - COLLECT: expect extension word cnt, where cnt runs 0..IMM_WORDS-1 (width clog2(IMM_WORDS), min 1).
- Reset (rstN=0, asynchronous):
  - State goes to IDLE and cnt to 0.
  - instruction, immediate, outValid, iamBubble, immDone and the saved opcode are all cleared to 0.
- Priority per edge: flush > stall > normal.
- flush = jumpBit | interruptBit, sampled at the edge. It takes effect even while stall=1:
  - State goes to IDLE and cnt to 0.
  - If inValid=1, inWord is processed through the IDLE path in the same edge. It is never treated as an extension word.
  - If inValid=0, outValid, iamBubble and immDone are cleared.
- stall=1 (no flush): every register holds, including the outputs.
- inValid=0 (no stall, no flush):
  - outValid, iamBubble and immDone go to 0.
  - instruction and immediate hold.
  - State and cnt hold, so a gap inside an immediate sequence is tolerated.
- IDLE with inValid=1:
  - instruction ← inWord, outValid=1, iamBubble=0, immDone=0.
  - If inWord[IMM_BIT]=1: save inWord, clear immediate to 0, go to COLLECT with cnt=0.
- COLLECT with inValid=1:
  - immediate word cnt ← inWord; other words hold.
  - instruction ← BUBBLE_INSTR with [DST_MSB:DST_LSB] replaced by the saved opcode's field.
  - outValid=1, iamBubble=1.
  - If cnt=IMM_WORDS-1: immDone=1, go to IDLE, cnt=0. Otherwise cnt+1, immDone=0.
- IMM_BIT is never inspected on extension words. An extension word with IMM_BIT set does not start a new sequence.

## Timing
- Latency: one cycle, inWord at edge N → outputs valid after edge N.
- Throughput: one word per cycle. No backpressure output; the upstream stage owns stall.
- immediate is stable from the immDone cycle until the next opcode with IMM_BIT set clears it.
- immDone is a single-cycle pulse per accepted final word.
- busy is a combinational decode of state.

## Test plan
Parameters are at defaults throughout.

1. Reset: drive rstN=0 mid-COLLECT with no clock edge → all outputs 0 and busy=0 immediately.
2. Plain stream: 0x1000, 0x2000 → instruction 0x1000 then 0x2000; outValid=1, iamBubble=0, busy=0.
3. Immediate: 0x0024, 0xBEEF, 0x1234 →
   - instruction 0x0024 (iamBubble=0), then 0x07A0, 0x07A0 (iamBubble=1).
   - immDone=1 on the third word; immediate=0x1234BEEF.
4. Stall: hold stall=1 for 3 cycles after 0x0024 while inWord changes → outputs unchanged. After release, 0xBEEF and 0x1234 yield immediate=0x1234BEEF.
5. Flush: 0x0024, 0xBEEF, then 0x3000 with jumpBit=1 →
   - instruction=0x3000, iamBubble=0, immDone=0, busy=0.
   - Repeat with interruptBit=1 and stall=1 on the flush cycle → same result.
6. Gap: 0x0024, inValid=0 for 2 cycles, 0xBEEF, 0x1234 → outValid=0 during the gap, busy stays 1, immediate=0x1234BEEF.
